// File: rtl/trap_ctrl_pkg.sv
// Shared CSR addresses, exception cause codes and the trap sequencer state encoding.
// The CSR address constants are also used by the CSR register stage.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  localparam logic [3:0] CAUSE_ILLEGAL_INST = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M      = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_EPC   = 3'd1,
    ST_WR_CAUSE = 3'd2,
    ST_JUMP     = 3'd3,
    ST_RET      = 3'd4
  } trap_state_t;

endpackage

// File: rtl/trap_ctrl.sv
// Commit-side trap sequencer: writes mepc/mcause, flushes and redirects on exceptions,
// flushes and redirects to mepc on MRET, otherwise passes pipeline CSR writes through.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [11:0] ADDR_MTVEC  = CSR_MTVEC,
  parameter logic [11:0] ADDR_MEPC   = CSR_MEPC,
  parameter logic [11:0] ADDR_MCAUSE = CSR_MCAUSE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_WAIT,
  input  logic        EXC_EN,
  input  logic [3:0]  EXC_CODE,
  input  logic [31:0] EXC_PC,
  input  logic        MRET_EN,
  input  logic        INST_WREN,
  input  logic [11:0] INST_WADDR,
  input  logic [31:0] INST_WDATA,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  output logic        CSR_WREN,
  output logic [11:0] CSR_WADDR,
  output logic [31:0] CSR_WDATA,
  output logic        FLUSH,
  output logic        JMP_DO,
  output logic [31:0] JMP_PC,
  output logic        BUSY
);

  trap_state_t state_reg, state_next;
  logic [31:0] epc_reg, epc_next;
  logic [31:0] cause_reg, cause_next;
  logic [31:0] ret_pc_reg, ret_pc_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= ST_IDLE;
      epc_reg    <= 32'h0;
      cause_reg  <= 32'h0;
      ret_pc_reg <= 32'h0;
    end else if (!MEM_WAIT) begin
      state_reg  <= state_next;
      epc_reg    <= epc_next;
      cause_reg  <= cause_next;
      ret_pc_reg <= ret_pc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    epc_next    = epc_reg;
    cause_next  = cause_reg;
    ret_pc_next = ret_pc_reg;
    CSR_WREN    = 1'b0;
    CSR_WADDR   = 12'h000;
    CSR_WDATA   = 32'h0;
    FLUSH       = 1'b0;
    JMP_DO      = 1'b0;
    JMP_PC      = 32'h0;

    case (state_reg)
      ST_IDLE: begin
        // The faulting instruction's own CSR write must not reach the register stage.
        CSR_WREN  = INST_WREN & ~EXC_EN;
        CSR_WADDR = EXC_EN ? 12'h000 : INST_WADDR;
        CSR_WDATA = INST_WDATA;
        if (EXC_EN) begin
          epc_next   = EXC_PC;
          cause_next = {28'b0, EXC_CODE};
          state_next = ST_WR_EPC;
        end else if (MRET_EN) begin
          // An mepc write retiring alongside MRET is not yet visible on the MEPC tap.
          ret_pc_next = (INST_WREN && INST_WADDR == ADDR_MEPC) ? INST_WDATA : MEPC;
          state_next  = ST_RET;
        end
      end
      ST_WR_EPC: begin
        CSR_WREN   = 1'b1;
        CSR_WADDR  = ADDR_MEPC;
        CSR_WDATA  = epc_reg;
        FLUSH      = 1'b1;
        state_next = ST_WR_CAUSE;
      end
      ST_WR_CAUSE: begin
        CSR_WREN   = 1'b1;
        CSR_WADDR  = ADDR_MCAUSE;
        CSR_WDATA  = cause_reg;
        FLUSH      = 1'b1;
        state_next = ST_JUMP;
      end
      ST_JUMP: begin
        FLUSH      = 1'b1;
        JMP_DO     = 1'b1;
        JMP_PC     = MTVEC & 32'hFFFF_FFFC;
        state_next = ST_IDLE;
      end
      ST_RET: begin
        FLUSH      = 1'b1;
        JMP_DO     = 1'b1;
        JMP_PC     = ret_pc_reg & 32'hFFFF_FFFC;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign BUSY = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized and directed bench for trap_ctrl against a queue-of-planned-cycles model.
module tb_trap_ctrl;

  logic        CLK = 1'b0;
  logic        RST, MEM_WAIT, EXC_EN, MRET_EN, INST_WREN;
  logic [3:0]  EXC_CODE;
  logic [31:0] EXC_PC, INST_WDATA, MTVEC, MEPC;
  logic [11:0] INST_WADDR;
  logic        CSR_WREN, FLUSH, JMP_DO, BUSY;
  logic [11:0] CSR_WADDR;
  logic [31:0] CSR_WDATA, JMP_PC;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  trap_ctrl dut (
    .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT), .EXC_EN(EXC_EN), .EXC_CODE(EXC_CODE),
    .EXC_PC(EXC_PC), .MRET_EN(MRET_EN), .INST_WREN(INST_WREN), .INST_WADDR(INST_WADDR),
    .INST_WDATA(INST_WDATA), .MTVEC(MTVEC), .MEPC(MEPC), .CSR_WREN(CSR_WREN),
    .CSR_WADDR(CSR_WADDR), .CSR_WDATA(CSR_WDATA), .FLUSH(FLUSH), .JMP_DO(JMP_DO),
    .JMP_PC(JMP_PC), .BUSY(BUSY)
  );

  // One planned output cycle of a trap sequence; jk: 0 no jump, 1 jump to live mtvec, 2 jump to pc.
  typedef struct packed {
    logic        wren;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [1:0]  jk;
    logic [31:0] pc;
  } beat_t;

  beat_t plan[$];

  logic        obs_wren, obs_busy, obs_flush, obs_jmp;
  logic [11:0] obs_waddr;
  logic [31:0] obs_jmp_pc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all outputs for the current cycle, then advance one clock and update the model.
  task automatic step();
    logic        e_wren, e_flush, e_jmp, e_busy;
    logic [11:0] e_waddr;
    logic [31:0] e_wdata, e_pc;
    beat_t b;
    #1;
    if (plan.size() == 0) begin
      e_wren  = INST_WREN & ~EXC_EN;
      e_waddr = EXC_EN ? 12'h000 : INST_WADDR;
      e_wdata = INST_WDATA;
      e_flush = 1'b0; e_jmp = 1'b0; e_pc = 32'h0; e_busy = 1'b0;
    end else begin
      b       = plan[0];
      e_wren  = b.wren; e_waddr = b.waddr; e_wdata = b.wdata;
      e_flush = 1'b1; e_busy = 1'b1;
      e_jmp   = (b.jk != 2'd0);
      e_pc    = (b.jk == 2'd1) ? {MTVEC[31:2], 2'b00} : (b.jk == 2'd2) ? b.pc : 32'h0;
    end
    check_eq("csr_wren",  {31'b0, CSR_WREN}, {31'b0, e_wren});
    check_eq("csr_waddr", {20'b0, CSR_WADDR}, {20'b0, e_waddr});
    check_eq("csr_wdata", CSR_WDATA, e_wdata);
    check_eq("flush",     {31'b0, FLUSH}, {31'b0, e_flush});
    check_eq("jmp_do",    {31'b0, JMP_DO}, {31'b0, e_jmp});
    check_eq("jmp_pc",    JMP_PC, e_pc);
    check_eq("busy",      {31'b0, BUSY}, {31'b0, e_busy});
    obs_wren = CSR_WREN; obs_waddr = CSR_WADDR; obs_flush = FLUSH;
    obs_jmp = JMP_DO; obs_jmp_pc = JMP_PC; obs_busy = BUSY;
    $display("cyc t=%0t rst=%0b wait=%0b exc=%0b mret=%0b -> wren=%0b waddr=%h wdata=%h flush=%0b jmp=%0b pc=%h busy=%0b",
             $time, RST, MEM_WAIT, EXC_EN, MRET_EN, CSR_WREN, CSR_WADDR, CSR_WDATA, FLUSH, JMP_DO, JMP_PC, BUSY);
    @(posedge CLK);
    if (RST) plan.delete();
    else if (!MEM_WAIT) begin
      if (plan.size() != 0) void'(plan.pop_front());
      else if (EXC_EN) begin
        plan.push_back('{1'b1, 12'h341, EXC_PC, 2'd0, 32'h0});
        plan.push_back('{1'b1, 12'h342, {28'b0, EXC_CODE}, 2'd0, 32'h0});
        plan.push_back('{1'b0, 12'h000, 32'h0, 2'd1, 32'h0});
      end else if (MRET_EN) begin
        b.pc = (INST_WREN && INST_WADDR == 12'h341) ? INST_WDATA : MEPC;
        plan.push_back('{1'b0, 12'h000, 32'h0, 2'd2, {b.pc[31:2], 2'b00}});
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    RST = 1'b0; MEM_WAIT = 1'b0; EXC_EN = 1'b0; MRET_EN = 1'b0; INST_WREN = 1'b0;
    EXC_CODE = 4'd0; EXC_PC = 32'h0; INST_WADDR = 12'h0; INST_WDATA = 32'h0;
  endtask

  initial begin
    idle_inputs();
    MTVEC = 32'h0; MEPC = 32'h0;
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    step();
    RST = 1'b0;
    step();

    // Pass-through of an ordinary CSR write
    INST_WREN = 1'b1; INST_WADDR = 12'h340; INST_WDATA = 32'hDEADBEEF;
    step();
    check_eq("pt_waddr", {20'b0, obs_waddr}, 32'h340);
    check_eq("pt_flush", {31'b0, obs_flush}, 32'h0);
    idle_inputs();

    // Exception sequence with mtvec low bits set
    MTVEC = 32'h1003;
    EXC_EN = 1'b1; EXC_CODE = 4'd11; EXC_PC = 32'h80;
    step();
    idle_inputs();
    step(); step(); step();
    check_eq("exc_jmp_pc", obs_jmp_pc, 32'h1000);
    step();
    check_eq("exc_busy_done", {31'b0, obs_busy}, 32'h0);

    // MRET forwarding a same-cycle mepc write
    MEPC = 32'h100; MRET_EN = 1'b1; INST_WREN = 1'b1; INST_WADDR = 12'h341; INST_WDATA = 32'h200;
    step();
    idle_inputs();
    step();
    check_eq("mret_fwd_pc", obs_jmp_pc, 32'h200);
    step();

    // Exception and MRET together: exception wins, INST write squashed
    EXC_EN = 1'b1; MRET_EN = 1'b1; EXC_CODE = 4'd3; EXC_PC = 32'h44;
    INST_WREN = 1'b1; INST_WADDR = 12'h340; INST_WDATA = 32'h5;
    step();
    check_eq("simul_squash", {31'b0, obs_wren}, 32'h0);
    idle_inputs();
    step(); step(); step(); step();

    // MEM_WAIT freeze during WR_CAUSE
    EXC_EN = 1'b1; EXC_CODE = 4'd2; EXC_PC = 32'hC0;
    step();
    idle_inputs();
    step();
    MEM_WAIT = 1'b1;
    step(); step();
    MEM_WAIT = 1'b0;
    step(); step(); step();

    // Reset during WR_EPC
    EXC_EN = 1'b1; EXC_CODE = 4'd11; EXC_PC = 32'h300;
    step();
    idle_inputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
    check_eq("rst_mid_busy", {31'b0, obs_busy}, 32'h0);
    step(); step(); step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      RST      = ($urandom_range(0, 59) == 0);
      MEM_WAIT = ($urandom_range(0, 4) == 0);
      EXC_EN   = ($urandom_range(0, 7) == 0);
      MRET_EN  = ($urandom_range(0, 5) == 0);
      EXC_CODE = 4'($urandom);
      EXC_PC   = $urandom;
      INST_WREN = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 4))
        0: INST_WADDR = 12'h341;
        1: INST_WADDR = 12'h342;
        2: INST_WADDR = 12'h305;
        3: INST_WADDR = 12'h340;
        default: INST_WADDR = 12'($urandom);
      endcase
      INST_WDATA = $urandom;
      MTVEC      = $urandom;
      MEPC       = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Commit-side trap sequencer that drives the single write port of the standard CSR register stage (WREN/WADDR/WDATA).
- On a synchronous exception it writes mepc and mcause, flushes the pipeline, then redirects fetch to mtvec.
- On MRET it flushes and redirects fetch to mepc.
- Outside trap sequences, ordinary CSR writes from the execute pipeline pass through to the CSR stage.

Parameters:
- ADDR_MTVEC, 12'h305, mtvec CSR address.
- ADDR_MEPC, 12'h341, mepc CSR address.
- ADDR_MCAUSE, 12'h342, mcause CSR address.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- MEM_WAIT  in  1  memory wait; freezes the FSM and input sampling
- EXC_EN  in  1  committing instruction raised an exception
- EXC_CODE  in  4  exception cause code
- EXC_PC  in  32  PC of the faulting instruction
- MRET_EN  in  1  committing instruction is MRET
- INST_WREN  in  1  pipeline CSR write enable
- INST_WADDR  in  12  pipeline CSR write address
- INST_WDATA  in  32  pipeline CSR write data
- MTVEC  in  32  direct tap of the current mtvec register
- MEPC  in  32  direct tap of the current mepc register
- CSR_WREN  out  1  to the CSR stage WREN
- CSR_WADDR  out  12  to the CSR stage WADDR
- CSR_WDATA  out  32  to the CSR stage WDATA
- FLUSH  out  1  pipeline flush
- JMP_DO  out  1  fetch redirect strobe
- JMP_PC  out  32  redirect target
- BUSY  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, WR_EPC, WR_CAUSE, JUMP, RET. The state register is synchronous.
- Reset: state=IDLE; latched epc=0, cause=0, ret_pc=0.
  - All outputs read 0, including CSR_WADDR=12'h000, so the CSR stage treats it as a no-op.
- MEM_WAIT=1:
  - No state transition and no input sampling.
  - Outputs keep their state-decoded values.
  - A write presented to the CSR stage while MEM_WAIT=1 is repeated on the next cycle. This is idempotent, so it is acceptable.
- IDLE, MEM_WAIT=0:
  - EXC_EN=1: latch epc=EXC_PC and cause={28'b0,EXC_CODE}; next state WR_EPC. EXC_EN has priority over MRET_EN when both are high.
  - MRET_EN=1 and EXC_EN=0: latch ret_pc; next state RET.
    - If INST_WREN=1 and INST_WADDR=ADDR_MEPC in the same cycle, ret_pc=INST_WDATA (forward the new value).
    - Otherwise ret_pc=MEPC.
  - CSR write outputs in IDLE are a combinational pass-through of INST_*.
    - Exception: when EXC_EN=1, CSR_WREN=0 and CSR_WADDR=0, because the faulting instruction's write is squashed.
  - FLUSH=0, JMP_DO=0.
- WR_EPC: CSR_WREN=1, CSR_WADDR=ADDR_MEPC, CSR_WDATA=epc, FLUSH=1; next state WR_CAUSE.
- WR_CAUSE: CSR_WREN=1, CSR_WADDR=ADDR_MCAUSE, CSR_WDATA=cause, FLUSH=1; next state JUMP.
- JUMP: CSR_WREN=0, FLUSH=1, JMP_DO=1, JMP_PC={MTVEC[31:2],2'b00} (direct mode only); next state IDLE.
- RET: FLUSH=1, JMP_DO=1, JMP_PC={ret_pc[31:2],2'b00}; next state IDLE.
- Outside IDLE:
  - INST_* writes are dropped; these instructions are being flushed.
  - EXC_EN and MRET_EN are ignored. No nesting and no queuing.
- Latency:
  - Exception: accept at cycle 0, mepc write at cycle 1, mcause write at cycle 2, redirect at cycle 3. Total 3 cycles of FLUSH.
  - MRET: accept at cycle 0, redirect at cycle 1.
- RST mid-sequence: return to IDLE on the next edge. Any remaining writes are abandoned and no redirect is issued.
- All data paths are 32 bits; no arithmetic.

Decomposition:
- Shared package holds:
  - CSR address constants (mtvec, mscratch, mepc, mcause), also used by the CSR stage.
  - Exception cause codes (illegal inst=2, breakpoint=3, ecall-M=11).
  - The FSM state encoding.
- Single flat module; no sub-module warranted.

Test Plan:
- Pass-through: IDLE, INST_WREN=1, WADDR=0x340, WDATA=0xDEADBEEF -> the same cycle shows CSR_WREN=1, 0x340, 0xDEADBEEF; FLUSH=0.
- Exception: EXC_EN=1, EXC_CODE=11, EXC_PC=0x80, MTVEC=0x1003 ->
  - cycle 1: write 0x341←0x80;
  - cycle 2: write 0x342←0x0000000B;
  - cycle 3: JMP_DO=1, JMP_PC=0x1000;
  - FLUSH high for cycles 1–3; BUSY low again at cycle 4.
- MRET with forwarding: MRET_EN=1, INST_WREN=1, INST_WADDR=0x341, INST_WDATA=0x200, MEPC=0x100 -> next cycle JMP_PC=0x200, FLUSH=1.
- Simultaneous events: EXC_EN=1 and MRET_EN=1 -> exception sequence taken; no RET state; the IDLE-cycle INST write is suppressed.
- MEM_WAIT freeze: assert MEM_WAIT for 2 cycles while in WR_CAUSE -> the mcause write is held 2 extra cycles; JUMP is delayed by exactly 2 cycles.
- Reset mid-sequence: RST asserted during WR_EPC -> next cycle IDLE with all outputs 0; no JMP_DO is ever seen.
